// File: rtl/bft_vc_arb_if.sv
// bft_vc_arb_if -- VC-side and link-side signals of the virtual-channel link
// arbiter, grouped into one bundle.
//   master : drives per-VC flits (i_vc_valid/i_vc_data) and credit returns,
//            and observes ready, link flit, credit status.
//   slave  : the arbiter itself.
interface bft_vc_arb_if #(
  parameter int NUM_CHANNELS = 2,
  parameter int DATA_WIDTH   = 32
);
  localparam int VCW = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0]            i_vc_valid;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] i_vc_data;
  logic [NUM_CHANNELS-1:0]            o_vc_ready;
  logic                               o_link_valid;
  logic [VCW-1:0]                     o_link_vc;
  logic [DATA_WIDTH-1:0]              o_link_data;
  logic [NUM_CHANNELS-1:0]            i_credit_return;
  logic [NUM_CHANNELS-1:0]            o_credit_avail;
  logic                               o_credit_err;

  modport master (
    output i_vc_valid, i_vc_data, i_credit_return,
    input  o_vc_ready, o_link_valid, o_link_vc, o_link_data,
           o_credit_avail, o_credit_err
  );

  modport slave (
    input  i_vc_valid, i_vc_data, i_credit_return,
    output o_vc_ready, o_link_valid, o_link_vc, o_link_data,
           o_credit_avail, o_credit_err
  );
endinterface

// File: rtl/bft_vc_arb.sv
// bft_vc_arb -- arbitrates NUM_CHANNELS virtual channels onto one physical
// link under per-VC credit flow control.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   bus (slave)    : i_vc_valid/i_vc_data per-VC flits, o_vc_ready one-hot
//                    grant (combinational), o_link_* registered link flit,
//                    i_credit_return per-VC return pulses, o_credit_avail
//                    per-VC nonzero credit, o_credit_err sticky overflow.
// Per-VC credit counter lives in bft_vc_credit, one instance per channel.

module bft_vc_credit #(
  parameter int CREDITS = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_grant,
  input  logic i_return,
  output logic o_avail,
  output logic o_overflow
);
  localparam int             CW  = $clog2(CREDITS + 1);
  localparam logic [CW-1:0]  MAX = CW'(CREDITS);
  localparam logic [CW-1:0]  ONE = CW'(1);

  logic [CW-1:0] credit_q, credit_d;

  // Grant and return in the same cycle cancel out. A return at full credit
  // is an overflow: counter saturates, event reported to the sticky flag.
  always_comb begin
    credit_d   = credit_q;
    o_overflow = 1'b0;
    if (i_grant && !i_return)
      credit_d = credit_q - ONE;
    else if (i_return && !i_grant) begin
      if (credit_q == MAX) o_overflow = 1'b1;
      else                 credit_d   = credit_q + ONE;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) credit_q <= MAX;
    else       credit_q <= credit_d;
  end

  assign o_avail = (credit_q != '0);
endmodule

module bft_vc_arb #(
  parameter int NUM_CHANNELS     = 2,
  parameter int DATA_WIDTH       = 32,
  parameter int CREDITS          = 4,
  parameter int FAIR_CHANNEL_ARB = 0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  bft_vc_arb_if.slave bus
);
  localparam int VCW = $clog2(NUM_CHANNELS);

  logic [NUM_CHANNELS-1:0] avail, ovf, elig, grant_oh;
  logic [VCW-1:0]          ptr_q, ptr_d, gnt_idx, link_vc_q;
  logic [DATA_WIDTH-1:0]   gnt_data, link_data_q;
  logic                    found, grant, link_valid_q, err_q;
  int                      j;

  genvar k;
  generate
    for (k = 0; k < NUM_CHANNELS; k++) begin : g_vc
      bft_vc_credit #(.CREDITS(CREDITS)) u_cred (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_grant   (grant_oh[k]),
        .i_return  (bus.i_credit_return[k]),
        .o_avail   (avail[k]),
        .o_overflow(ovf[k])
      );
    end
  endgenerate

  // Eligibility uses registered credit only, so a same-cycle return never
  // makes an empty VC eligible.
  assign elig = bus.i_vc_valid & avail;

  always_comb begin
    found   = 1'b0;
    gnt_idx = '0;
    j       = 0;
    if (FAIR_CHANNEL_ARB == 0) begin
      for (int i = 0; i < NUM_CHANNELS; i++)
        if (!found && elig[i]) begin
          found   = 1'b1;
          gnt_idx = VCW'(i);
        end
    end else begin
      // Round-robin: start one past the last winner, wrap around.
      for (int i = 1; i <= NUM_CHANNELS; i++) begin
        j = int'(ptr_q) + i;
        if (j >= NUM_CHANNELS) j = j - NUM_CHANNELS;
        if (!found && elig[j]) begin
          found   = 1'b1;
          gnt_idx = VCW'(j);
        end
      end
    end
    grant    = found && !i_rst;
    grant_oh = '0;
    if (grant) grant_oh[gnt_idx] = 1'b1;
    ptr_d    = grant ? gnt_idx : ptr_q;
    gnt_data = bus.i_vc_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ptr_q        <= VCW'(NUM_CHANNELS - 1);
      link_valid_q <= 1'b0;
      link_vc_q    <= '0;
      link_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      ptr_q        <= ptr_d;
      link_valid_q <= grant;
      if (grant) begin
        link_vc_q   <= gnt_idx;
        link_data_q <= gnt_data;
      end
      if (|ovf) err_q <= 1'b1;
    end
  end

  assign bus.o_vc_ready     = grant_oh;
  assign bus.o_link_valid   = link_valid_q;
  assign bus.o_link_vc      = link_vc_q;
  assign bus.o_link_data    = link_data_q;
  assign bus.o_credit_avail = avail;
  assign bus.o_credit_err   = err_q;
endmodule

// File: tb/tb_bft_vc_arb.sv
// tb_bft_vc_arb -- drives a fixed-priority and a round-robin instance with the
// same stimulus; a reference model predicts grants and pushes expected link
// flits to per-instance scoreboard queues, popped when o_link_valid rises.
module tb_bft_vc_arb;
  localparam int N  = 2;
  localparam int DW = 32;
  localparam int CR = 4;
  localparam int VW = $clog2(N);

  typedef struct { int vc; logic [DW-1:0] d; } ent_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [N-1:0]    valid, ret;
  logic [N*DW-1:0] data;

  bft_vc_arb_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) if0 ();
  bft_vc_arb_if #(.NUM_CHANNELS(N), .DATA_WIDTH(DW)) if1 ();

  assign if0.i_vc_valid = valid;  assign if1.i_vc_valid = valid;
  assign if0.i_vc_data  = data;   assign if1.i_vc_data  = data;
  assign if0.i_credit_return = ret;
  assign if1.i_credit_return = ret;

  bft_vc_arb #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .CREDITS(CR), .FAIR_CHANNEL_ARB(0))
    u_fix (.i_clk(clk), .i_rst(rst), .bus(if0));
  bft_vc_arb #(.NUM_CHANNELS(N), .DATA_WIDTH(DW), .CREDITS(CR), .FAIR_CHANNEL_ARB(1))
    u_rr  (.i_clk(clk), .i_rst(rst), .bus(if1));

  logic [N-1:0]  o_rdy[2], o_av[2];
  logic          o_lv[2], o_err[2];
  logic [VW-1:0] o_lvc[2];
  logic [DW-1:0] o_ld[2];
  assign o_rdy[0] = if0.o_vc_ready;     assign o_rdy[1] = if1.o_vc_ready;
  assign o_av[0]  = if0.o_credit_avail; assign o_av[1]  = if1.o_credit_avail;
  assign o_lv[0]  = if0.o_link_valid;   assign o_lv[1]  = if1.o_link_valid;
  assign o_err[0] = if0.o_credit_err;   assign o_err[1] = if1.o_credit_err;
  assign o_lvc[0] = if0.o_link_vc;      assign o_lvc[1] = if1.o_link_vc;
  assign o_ld[0]  = if0.o_link_data;    assign o_ld[1]  = if1.o_link_data;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // reference model, index 0 = fixed priority, 1 = round-robin
  int            m_cred[2][N];
  int            m_ptr[2];
  bit            m_err[2];
  bit            m_lv[2];
  int            m_lvc[2];
  logic [DW-1:0] m_ld[2];
  int            m_g[2];     // model grant of last step, -1 = none
  logic [N-1:0]  obs_rdy[2]; // observed ready of last step
  ent_t          q0[$], q1[$];

  function automatic int mgrant(int d);
    if (d == 0) begin
      for (int i = 0; i < N; i++)
        if (valid[i] && m_cred[d][i] > 0) return i;
    end else begin
      for (int i = 1; i <= N; i++) begin
        int x = (m_ptr[d] + i) % N;
        if (valid[x] && m_cred[d][x] > 0) return x;
      end
    end
    return -1;
  endfunction

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < N; k++) m_cred[d][k] = CR;
      m_ptr[d] = N - 1; m_err[d] = 0; m_lv[d] = 0; m_lvc[d] = 0; m_ld[d] = '0;
    end
    q0.delete(); q1.delete();
  endtask

  // One clock: check combinational ready at negedge, advance model at the
  // edge, check registered outputs 1 time unit after.
  task automatic step();
    ent_t e;
    logic [N-1:0] exp_oh;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      m_g[d] = rst ? -1 : mgrant(d);
      exp_oh = '0;
      if (m_g[d] >= 0) exp_oh[m_g[d]] = 1'b1;
      obs_rdy[d] = o_rdy[d];
      chk(d ? "rr_ready" : "fix_ready", 64'(o_rdy[d]), 64'(exp_oh));
      if (m_g[d] >= 0) begin
        e.vc = m_g[d];
        e.d  = data[m_g[d]*DW +: DW];
        if (d == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    @(posedge clk);
    if (rst) mreset();
    else begin
      for (int d = 0; d < 2; d++) begin
        for (int k = 0; k < N; k++) begin
          bit g = (m_g[d] == k);
          if (g && !ret[k]) m_cred[d][k]--;
          else if (ret[k] && !g) begin
            if (m_cred[d][k] == CR) m_err[d] = 1;
            else m_cred[d][k]++;
          end
        end
        if (m_g[d] >= 0) m_ptr[d] = m_g[d];
        m_lv[d] = (m_g[d] >= 0);
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      logic [N-1:0] av;
      chk(d ? "rr_lvalid" : "fix_lvalid", 64'(o_lv[d]), 64'(m_lv[d]));
      if (o_lv[d]) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0)
          chk(d ? "rr_sb_empty" : "fix_sb_empty", 64'(0), 64'(1));
        else begin
          e = (d == 0) ? q0.pop_front() : q1.pop_front();
          m_lvc[d] = e.vc; m_ld[d] = e.d;
        end
      end
      chk(d ? "rr_lvc" : "fix_lvc", 64'(o_lvc[d]), 64'(m_lvc[d]));
      chk(d ? "rr_ldata" : "fix_ldata", 64'(o_ld[d]), 64'(m_ld[d]));
      for (int k = 0; k < N; k++) av[k] = (m_cred[d][k] != 0);
      chk(d ? "rr_avail" : "fix_avail", 64'(o_av[d]), 64'(av));
      chk(d ? "rr_err" : "fix_err", 64'(o_err[d]), 64'(m_err[d]));
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [N-1:0] r);
    valid = v; ret = r;
    data  = {$urandom(), $urandom()};
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1; drive('0, '0);
    repeat (cycles) step();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; valid = '0; ret = '0; data = '0;
    mreset();
    do_reset(2);
    chk("rst_avail", 64'(o_av[0]), 64'(2'b11));
    chk("rst_lvalid", 64'(o_lv[0]), 64'(0));

    // fixed priority drains VC0 then VC1, then stalls on zero credit
    for (int i = 0; i < 10; i++) begin
      drive(2'b11, '0); step();
      chk("fix_seq", 64'(obs_rdy[0]), 64'(i < 4 ? 2'b01 : (i < 8 ? 2'b10 : 2'b00)));
    end
    chk("fix_drained", 64'(o_av[0]), 64'(2'b00));

    // round-robin alternates with per-grant credit returns one cycle later
    do_reset(1);
    ret = '0;
    for (int i = 0; i < 8; i++) begin
      logic [N-1:0] r;
      r = '0;
      if (i > 0 && m_g[1] >= 0) r[m_g[1]] = 1'b1;
      drive(2'b11, r); step();
      chk("rr_alt", 64'(obs_rdy[1]), 64'(i % 2 ? 2'b10 : 2'b01));
      chk("rr_lag", 64'(o_lvc[1]), 64'(i % 2));
    end

    // zero-credit VC0 becomes eligible only the cycle after its return
    do_reset(1);
    for (int i = 0; i < 4; i++) begin drive(2'b01, '0); step(); end
    drive(2'b01, 2'b01); step();
    chk("ret_nogrant", 64'(obs_rdy[0]), 64'(0));
    chk("ret_nolink", 64'(o_lv[0]), 64'(0));
    drive(2'b01, '0); step();
    chk("ret_grant", 64'(obs_rdy[0]), 64'(2'b01));
    chk("ret_link", 64'(o_lv[0]), 64'(1));

    // simultaneous grant + return on VC1 at credit 2 leaves credit at 2
    do_reset(1);
    for (int i = 0; i < 2; i++) begin drive(2'b10, '0); step(); end
    drive(2'b10, 2'b10); step();
    chk("both_grant", 64'(obs_rdy[0]), 64'(2'b10));
    drive('0, '0); step();
    chk("both_avail", 64'(o_av[0][1]), 64'(1));
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      drive(2'b10, '0); step();
      if (obs_rdy[0][1]) cnt++;
    end
    chk("both_remaining", 64'(cnt), 64'(2));

    // overflow: return at full credit sets sticky error, credit stays 4
    do_reset(1);
    drive('0, 2'b01); step();
    chk("ovf_err", 64'(o_err[0]), 64'(1));
    for (int i = 0; i < 3; i++) begin
      drive('0, '0); step();
      chk("ovf_hold", 64'(o_err[0]), 64'(1));
    end
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      drive(2'b01, '0); step();
      if (obs_rdy[0][0]) cnt++;
    end
    chk("ovf_credit", 64'(cnt), 64'(4));

    // mid-operation reset restores credits, clears error, VC0 wins first
    for (int i = 0; i < 3; i++) begin drive(2'b11, 2'b10); step(); end
    drive(2'b11, 2'b11); rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_avail_fix", 64'(o_av[0]), 64'(2'b11));
    chk("mrst_avail_rr", 64'(o_av[1]), 64'(2'b11));
    chk("mrst_err", 64'(o_err[0]), 64'(0));
    chk("mrst_lvalid", 64'(o_lv[1]), 64'(0));
    drive(2'b11, '0); step();
    chk("mrst_first_fix", 64'(obs_rdy[0]), 64'(2'b01));
    chk("mrst_first_rr", 64'(obs_rdy[1]), 64'(2'b01));
    for (int i = 0; i < 5; i++) begin drive(2'b11, '0); step(); end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
